// File: rtl/rx_stamp_checker.sv
// rx_stamp_checker: inline rx packet-bus stage that passes every word through
// with one register of delay, pulls the embedded 64-bit timestamp out of each
// packet, and publishes one-way latency plus running min/max/sample/error stats.
//
// Handshake: a word transfers on a rising clk edge when in_wr & in_rdy; in_rdy
// is out_rdy combinationally, and out_wr marks a valid word on the output
// register for exactly one cycle per accepted word.
module rx_stamp_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int CTRL_WIDTH   = 8,
  parameter int STAMP_WIDTH  = 64,
  parameter int OFFSET_WIDTH = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [CTRL_WIDTH-1:0]   in_ctrl,
  input  logic                    in_wr,
  output logic                    in_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]   out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  input  logic [STAMP_WIDTH-1:0]  counter_val,
  input  logic [OFFSET_WIDTH-1:0] stamp_offset,
  input  logic                    clear,
  output logic [STAMP_WIDTH-1:0]  latency,
  output logic                    latency_valid,
  output logic [STAMP_WIDTH-1:0]  lat_min,
  output logic [STAMP_WIDTH-1:0]  lat_max,
  output logic [CNT_WIDTH-1:0]    sample_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    HDRS = 2'd0,
    DATA = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
  logic                    out_wr_q, out_wr_d;
  logic [STAMP_WIDTH-1:0]  arrival_q, arrival_d;
  logic [STAMP_WIDTH-1:0]  stamp_q, stamp_d;
  logic                    stamp_seen_q, stamp_seen_d;
  logic [OFFSET_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [STAMP_WIDTH-1:0]  latency_q, latency_d;
  logic                    latency_valid_q, latency_valid_d;
  logic [STAMP_WIDTH-1:0]  lat_min_q, lat_min_d;
  logic [STAMP_WIDTH-1:0]  lat_max_q, lat_max_d;
  logic [CNT_WIDTH-1:0]    sample_count_q, sample_count_d;
  logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;

  logic                    accept;
  logic [STAMP_WIDTH-1:0]  diff;
  logic                    sample_ok;
  logic [OFFSET_WIDTH-1:0] idx_inc;
  logic                    idx_sat;

  assign in_rdy    = out_rdy;
  assign accept    = in_wr & out_rdy;
  // Modulo subtraction; a set MSB means the stamp is ahead of the arrival time.
  assign diff      = arrival_q - stamp_q;
  assign sample_ok = stamp_seen_q & ~diff[STAMP_WIDTH-1];
  assign idx_sat   = (word_idx_q == {OFFSET_WIDTH{1'b1}});
  assign idx_inc   = word_idx_q + OFFSET_WIDTH'(1);

  // Next-state logic: pass-through register, packet parser FSM, stats update.
  always_comb begin
    state_d         = state_q;
    out_data_d      = out_data_q;
    out_ctrl_d      = out_ctrl_q;
    out_wr_d        = accept;
    arrival_d       = arrival_q;
    stamp_d         = stamp_q;
    stamp_seen_d    = stamp_seen_q;
    word_idx_d      = word_idx_q;
    latency_d       = latency_q;
    latency_valid_d = 1'b0;
    lat_min_d       = lat_min_q;
    lat_max_d       = lat_max_q;
    sample_count_d  = sample_count_q;
    err_count_d     = err_count_q;

    if (accept) begin
      out_data_d = in_data;
      out_ctrl_d = in_ctrl;
    end

    case (state_q)
      HDRS, EVAL: begin
        // EVAL resolves the finished packet and then behaves like HDRS so a
        // back-to-back packet can start on the very same cycle.
        if (state_q == EVAL) begin
          state_d = HDRS;
          if (sample_ok) begin
            latency_d       = diff;
            latency_valid_d = 1'b1;
            if (sample_count_q != {CNT_WIDTH{1'b1}})
              sample_count_d = sample_count_q + CNT_WIDTH'(1);
            if (diff < lat_min_q) lat_min_d = diff;
            if (diff > lat_max_q) lat_max_d = diff;
          end else if (err_count_q != {CNT_WIDTH{1'b1}}) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
          end
        end
        if (accept && (in_ctrl == '0)) begin
          arrival_d    = counter_val;
          word_idx_d   = '0;
          stamp_seen_d = (stamp_offset == '0);
          if (stamp_offset == '0) stamp_d = in_data;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          // A saturated index never advances, so it can never match twice.
          if (!idx_sat) begin
            word_idx_d = idx_inc;
            if (idx_inc == stamp_offset) begin
              stamp_d      = in_data;
              stamp_seen_d = 1'b1;
            end
          end
          if (in_ctrl != '0) state_d = EVAL;
        end
      end
      default: state_d = HDRS;
    endcase

    // clear overrides any same-cycle stats update; latency_valid still pulses.
    if (clear) begin
      latency_d      = '0;
      lat_min_d      = {STAMP_WIDTH{1'b1}};
      lat_max_d      = '0;
      sample_count_d = '0;
      err_count_d    = '0;
    end
  end

  // State and output registers; everything clears to zero except lat_min.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= HDRS;
      out_data_q      <= '0;
      out_ctrl_q      <= '0;
      out_wr_q        <= 1'b0;
      arrival_q       <= '0;
      stamp_q         <= '0;
      stamp_seen_q    <= 1'b0;
      word_idx_q      <= '0;
      latency_q       <= '0;
      latency_valid_q <= 1'b0;
      lat_min_q       <= {STAMP_WIDTH{1'b1}};
      lat_max_q       <= '0;
      sample_count_q  <= '0;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      out_data_q      <= out_data_d;
      out_ctrl_q      <= out_ctrl_d;
      out_wr_q        <= out_wr_d;
      arrival_q       <= arrival_d;
      stamp_q         <= stamp_d;
      stamp_seen_q    <= stamp_seen_d;
      word_idx_q      <= word_idx_d;
      latency_q       <= latency_d;
      latency_valid_q <= latency_valid_d;
      lat_min_q       <= lat_min_d;
      lat_max_q       <= lat_max_d;
      sample_count_q  <= sample_count_d;
      err_count_q     <= err_count_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_ctrl      = out_ctrl_q;
  assign out_wr        = out_wr_q;
  assign latency       = latency_q;
  assign latency_valid = latency_valid_q;
  assign lat_min       = lat_min_q;
  assign lat_max       = lat_max_q;
  assign sample_count  = sample_count_q;
  assign err_count     = err_count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_rx_stamp_checker.sv
// Bench for rx_stamp_checker: packet driver, pass-through and latency
// scoreboards, and a small stats model checked after each scenario.
module tb_rx_stamp_checker;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [63:0] counter_val;
  logic [7:0]  stamp_offset;
  logic        clear;
  logic [63:0] latency;
  logic        latency_valid;
  logic [63:0] lat_min;
  logic [63:0] lat_max;
  logic [31:0] sample_count;
  logic [31:0] err_count;
  logic [1:0]  state_dbg;

  rx_stamp_checker dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .counter_val(counter_val), .stamp_offset(stamp_offset), .clear(clear),
    .latency(latency), .latency_valid(latency_valid),
    .lat_min(lat_min), .lat_max(lat_max),
    .sample_count(sample_count), .err_count(err_count), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [71:0] exp_q[$];   // {ctrl, data} of each accepted word
  logic [63:0] lat_q[$];   // expected latency per latency_valid pulse

  // Stats model
  logic [63:0] m_lat, m_min, m_max;
  logic [31:0] m_cnt, m_err;
  bit          toggle_en;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_lat = '0; m_min = '1; m_max = '0; m_cnt = '0; m_err = '0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr) begin
        if (exp_q.size() == 0) check_eq("out_unexpected", 1, 0);
        else check_eq("out_word", {out_ctrl, out_data}, exp_q.pop_front());
      end
      if (latency_valid) begin
        if (lat_q.size() == 0) check_eq("lat_unexpected", 1, 0);
        else check_eq("latency", latency, lat_q.pop_front());
      end
    end
  end

  // Drive one word until accepted; returns at the negedge after acceptance.
  task automatic drive_word(input logic [7:0] c, input logic [63:0] d, input logic [63:0] cv);
    bit acc = 0;
    in_ctrl = c; in_data = d; counter_val = cv; in_wr = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      if (toggle_en) out_rdy = ~out_rdy; else out_rdy = 1'b1;
      #1;
      if (toggle_en) check_eq("in_rdy_tracks", in_rdy, out_rdy);
      acc = out_rdy;
      @(posedge clk);
      if (acc) exp_q.push_back({c, d});
      @(negedge clk);
    end
    if (!acc) check_eq("accept_timeout", 0, 1);
    in_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    in_wr = 1'b0; out_rdy = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One packet; stamp sits at data index stamp_idx (none if >= n_data).
  task automatic send_pkt(input int n_hdr, input int n_data, input int stamp_idx,
                          input logic [63:0] stamp, input logic [63:0] arrival,
                          input bit clr_eop);
    logic [63:0] d, diff;
    bit ok;
    for (int h = 0; h < n_hdr; h++)
      drive_word(8'hff, {$urandom, $urandom}, {$urandom, $urandom});
    for (int i = 0; i < n_data; i++) begin
      d = (i == stamp_idx) ? stamp : {$urandom, $urandom};
      drive_word((i == n_data - 1) ? 8'h01 : 8'h00, d,
                 (i == 0) ? arrival : {$urandom, $urandom});
    end
    // Now in the EVAL cycle.
    diff = arrival - stamp;
    ok   = (stamp_idx < n_data) && !diff[63];
    if (clr_eop) begin
      clear = 1'b1;
      if (ok) lat_q.push_back(64'h0);
      model_clear();
      @(negedge clk);
      clear = 1'b0;
    end else if (ok) begin
      lat_q.push_back(diff);
      m_lat = diff; m_cnt++;
      if (diff < m_min) m_min = diff;
      if (diff > m_max) m_max = diff;
    end else begin
      m_err++;
    end
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_latency"}, latency, m_lat);
    check_eq({tag, "_lat_min"}, lat_min, m_min);
    check_eq({tag, "_lat_max"}, lat_max, m_max);
    check_eq({tag, "_samples"}, sample_count, m_cnt);
    check_eq({tag, "_errors"}, err_count, m_err);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0; out_rdy = 1'b1;
    counter_val = '0; stamp_offset = 8'd1; clear = 1'b0; toggle_en = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_stats("reset");
    check_eq("reset_out_wr", out_wr, 0);
    check_eq("reset_lat_valid", latency_valid, 0);
    check_eq("reset_state", state_dbg, 0);
    reset = 1'b0;
    idle(2);

    // 1: single packet, latency 0x80, valid two cycles after EOP acceptance
    send_pkt(1, 4, 1, 64'h100, 64'h180, 0);
    check_eq("t1_no_early_valid", latency_valid, 0);
    @(negedge clk);
    check_eq("t1_valid_timing", latency_valid, 1);
    idle(3);
    check_stats("t1");

    // 2: three back-to-back packets (second has no header)
    pulse_clear();
    send_pkt(1, 3, 1, 64'h1000, 64'h1050, 0);
    send_pkt(0, 4, 1, 64'h2000, 64'h2020, 0);
    send_pkt(2, 3, 1, 64'h3000, 64'h3090, 0);
    idle(4);
    check_stats("t2");

    // 3: negative latency
    send_pkt(1, 3, 1, 64'h200, 64'h100, 0);
    idle(4);
    check_stats("t3");

    // 4: stamp beyond packet end
    stamp_offset = 8'd10;
    send_pkt(1, 3, 10, 64'h10, 64'h40, 0);
    idle(4);
    check_stats("t4");

    // 5: out_rdy toggling, stamp at offset 2 then offset 0, then clear in EVAL
    toggle_en = 1;
    stamp_offset = 8'd2;
    send_pkt(1, 5, 2, 64'h5000, 64'h5077, 0);
    stamp_offset = 8'd0;
    send_pkt(1, 3, 0, 64'h6000, 64'h6011, 0);
    toggle_en = 0;
    idle(4);
    check_stats("t5");
    toggle_en = 1;
    send_pkt(1, 4, 0, 64'h7000, 64'h7033, 1);
    toggle_en = 0;
    idle(4);
    check_stats("t5_clear");

    // 6: reset asserted during the second data word
    stamp_offset = 8'd1;
    send_pkt(1, 3, 1, 64'h800, 64'h8a0, 0);
    idle(4);
    drive_word(8'hff, 64'h1111, 64'h0);
    drive_word(8'h00, 64'h2222, 64'h900);
    in_ctrl = 8'h00; in_data = 64'h3333; in_wr = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_async_out_wr", out_wr, 0);
    check_eq("t6_async_lat_min", lat_min, 64'hffff_ffff_ffff_ffff);
    check_eq("t6_async_samples", sample_count, 0);
    check_eq("t6_async_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b0; in_wr = 1'b0;
    model_clear();
    idle(2);
    send_pkt(1, 4, 1, 64'ha00, 64'ha42, 0);
    idle(4);
    check_stats("t6");

    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("lat_q_drained", lat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_stamp_checker.md
Name: rx_stamp_checker

Overview:
- Receive-side counterpart to the tx timestamp counter: extracts the 64-bit timestamp that the generator's counter placed in each packet and measures one-way latency.
- Latency = local counter_val sampled at the packet's first data word minus the embedded stamp.
- Sits inline on the rx packet bus between the MAC rx queue and the output port lookup, with one register stage of pass-through.
- Publishes per-packet latency plus running min, max, sample and error counts for the register block.

Parameters:
- DATA_WIDTH, 64, packet bus data width
- CTRL_WIDTH, 8, packet bus ctrl width
- STAMP_WIDTH, 64, width of timestamp and counter_val (integer part of the 96/32 counter)
- OFFSET_WIDTH, 8, width of the stamp word offset
- CNT_WIDTH, 32, width of sample and error counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  upstream packet data
- in_ctrl  in  CTRL_WIDTH  upstream ctrl; nonzero marks a module header or the last data word
- in_wr  in  1  upstream word valid
- in_rdy  out  1  upstream ready
- out_data  out  DATA_WIDTH  downstream data
- out_ctrl  out  CTRL_WIDTH  downstream ctrl
- out_wr  out  1  downstream word valid
- out_rdy  in  1  downstream ready
- counter_val  in  STAMP_WIDTH  live timestamp from the stamp counter
- stamp_offset  in  OFFSET_WIDTH  data-word index (0 = first ctrl==0 word) holding the stamp; quasi-static
- clear  in  1  one-cycle pulse; resets statistics only
- latency  out  STAMP_WIDTH  last valid latency
- latency_valid  out  1  one-cycle pulse when latency updates
- lat_min  out  STAMP_WIDTH  minimum valid latency since reset/clear
- lat_max  out  STAMP_WIDTH  maximum valid latency since reset/clear
- sample_count  out  CNT_WIDTH  number of valid samples
- err_count  out  CNT_WIDTH  packets with a negative latency or a missing stamp word

Behaviour:
- Reset, asynchronous: all outputs and registers go to 0, except lat_min, which goes to all-ones. The FSM goes to HDRS.
- Flow control: in_rdy = out_rdy (combinational). A word is accepted when in_wr & in_rdy.
- Pass-through: an accepted word appears on out_data/out_ctrl with out_wr=1 exactly one cycle later, unmodified. Otherwise out_wr=0.
- HDRS state, on an accepted word:
  - ctrl!=0: stay in HDRS (module header).
  - ctrl==0: latch arrival=counter_val, set word_idx=0, clear stamp_seen, go to DATA. If stamp_offset==0, latch stamp and set stamp_seen on this same word.
- DATA state, on each accepted word:
  - Increment word_idx.
  - If word_idx (post-increment) == stamp_offset, latch stamp=in_data and set stamp_seen.
  - ctrl!=0 marks the last word; this word can itself hold the stamp. Go to EVAL.
- EVAL state, single cycle; the bus may keep accepting words during it:
  - Compute diff = arrival - stamp, modulo 2^STAMP_WIDTH.
  - Valid sample (stamp_seen and diff MSB clear):
    - latency <= diff; pulse latency_valid.
    - sample_count +1, saturating at all-ones.
    - lat_min <= min(lat_min, diff); lat_max <= max(lat_max, diff).
  - Otherwise: err_count +1, saturating; no latency_valid pulse.
  - Next state: HDRS.
  - latency_valid rises 2 cycles after the last word is accepted.
- Back-to-back packets: a header word accepted while in EVAL is treated as in HDRS. A ctrl==0 word accepted in EVAL also starts a new packet. Implement by evaluating the HDRS rules in EVAL as well.
- word_idx saturates at all-ones and never wraps. A packet longer than 2^OFFSET_WIDTH words cannot match a second time.
- clear:
  - Sets lat_min=all-ones and lat_max=0, and zeroes latency, sample_count and err_count.
  - Does not affect the FSM or the datapath.
  - If clear coincides with an EVAL update, clear wins and the sample is discarded, though latency_valid still pulses.
- Reset mid-packet: the partial packet is discarded and the next word is parsed from HDRS.
- out_rdy low: no acceptance, so the FSM, counters and captures all hold.

Test Plan:
1. Single packet with 1 header word, stamp_offset=1, stamp word=0x100, counter_val=0x180 at the first data word, 4 data words.
   - Output words are identical, each 1 cycle later.
   - latency=0x80 with latency_valid 2 cycles after EOP.
   - lat_min=lat_max=0x80, sample_count=1.
2. Three back-to-back packets with latencies 0x50, 0x20, 0x90 and no idle between them.
   - sample_count=3, lat_min=0x20, lat_max=0x90, latency=0x90.
   - No words lost or duplicated.
3. Stamp 0x200 with arrival 0x100 (negative latency).
   - err_count=1, no latency_valid, min/max unchanged.
4. stamp_offset=10 with a 3-data-word packet (missing stamp).
   - err_count increments, sample_count unchanged.
5. out_rdy toggling 1010… mid-packet.
   - in_rdy tracks out_rdy; the stamp is captured from the correct word; latency is correct.
   - clear pulsed while EVAL is active: all stats at reset values afterwards.
6. Assert reset in the 2nd data word, then send a full packet.
   - Outputs return to reset values asynchronously.
   - The following packet yields a correct single sample, sample_count=1.
